// File: rtl/acc_ctrl.sv
// acc_ctrl: control FSM of an 8-bit accumulator machine.
// Fetches byte instructions, decodes them and strobes the datapath.
//
// Ports:
//   clk        rising-edge clock
//   CLB        async active-low clear
//   start      leaves IDLE on the next cycle
//   imem_rdata instruction byte {opcode, operand}
//   imem_valid imem_rdata valid for the pending fetch
//   acc_zero   accumulator is zero (branch condition)
//   imem_req   fetch request (FETCH state)
//   imem_addr  fetch address (pc)
//   loadAcc    accumulator load strobe (EXEC only)
//   SelAcc     acc source: 00 ALU, 01 reg file, 10 immediate
//   imm        immediate operand (IR[3:0])
//   alu_op     000 ADD 001 SUB 010 AND 011 OR 100 XOR
//   rf_addr    register file index (IR[3:0])
//   rf_we      register file write strobe (EXEC only)
//   busy       running an instruction
//   halted     stopped by HLT until reset
//
// Build option: ACC_CTRL_BRANCH_EN adds JZ (1010) / JNZ (1011);
// without it both run as NOP and acc_zero is ignored.

module acc_ctrl #(
  parameter logic [7:0] PC_RST = 8'h00
) (
  input  logic       clk,
  input  logic       CLB,
  input  logic       start,
  input  logic [7:0] imem_rdata,
  input  logic       imem_valid,
  input  logic       acc_zero,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  output logic       loadAcc,
  output logic [1:0] SelAcc,
  output logic [3:0] imm,
  output logic [2:0] alu_op,
  output logic [3:0] rf_addr,
  output logic       rf_we,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JNZ = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [1:0] f_sel(
    input logic [3:0] op
  );
    logic [1:0] s;
    s = 2'b00;
    case (op)
      OP_LDI:  s = 2'b10;
      OP_LDR:  s = 2'b01;
      default: s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] f_alu(
    input logic [3:0] op
  );
    logic [2:0] a;
    a = 3'b000;
    case (op)
      OP_ADD:  a = 3'b000;
      OP_SUB:  a = 3'b001;
      OP_AND:  a = 3'b010;
      OP_OR:   a = 3'b011;
      OP_XOR:  a = 3'b100;
      default: a = 3'b000;
    endcase
    return a;
  endfunction

  function automatic logic f_load(
    input logic [3:0] op
  );
    logic l;
    l = 1'b0;
    case (op)
      OP_LDI, OP_LDR,
      OP_ADD, OP_SUB,
      OP_AND, OP_OR,
      OP_XOR:  l = 1'b1;
      default: l = 1'b0;
    endcase
    return l;
  endfunction

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic       r_req;
  logic       r_load;
  logic       r_we;
  logic [1:0] r_sel;
  logic [2:0] r_alu;
  logic       r_busy;
  logic       r_halt;

  logic [3:0] w_op;
  logic [3:0] w_opr;
  logic [3:0] w_fop;
  logic       w_jump;
  logic       w_br_take;

  assign w_op  = r_ir[7:4];
  assign w_opr = r_ir[3:0];
  assign w_fop = imem_rdata[7:4];

`ifdef ACC_CTRL_BRANCH_EN
  always_comb begin
    w_br_take = 1'b0;
    case (w_op)
      OP_JZ:   w_br_take = acc_zero;
      OP_JNZ:  w_br_take = !acc_zero;
      default: w_br_take = 1'b0;
    endcase
  end
`else
  logic w_unused_acc_zero;
  assign w_unused_acc_zero = acc_zero;
  assign w_br_take = 1'b0;
`endif

  assign w_jump = (w_op == OP_JMP) || w_br_take;

  // Strobes are registered: they are armed in DECODE so
  // they are high for exactly the EXEC cycle.
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      r_state <= S_IDLE;
      r_pc    <= PC_RST;
      r_ir    <= 8'h00;
      r_req   <= 1'b0;
      r_load  <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 2'b00;
      r_alu   <= 3'b000;
      r_busy  <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            r_ir    <= imem_rdata;
            r_pc    <= r_pc + 8'h01;
            r_req   <= 1'b0;
            r_sel   <= f_sel(w_fop);
            r_alu   <= f_alu(w_fop);
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_load  <= f_load(w_op);
          r_we    <= (w_op == OP_STR);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_load <= 1'b0;
          r_we   <= 1'b0;
          r_sel  <= 2'b00;
          r_alu  <= 3'b000;
          if (w_jump) begin
            r_pc <= {4'h0, w_opr};
          end
          if (w_op == OP_HLT) begin
            r_state <= S_HALT;
            r_busy  <= 1'b0;
            r_halt  <= 1'b1;
          end else begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_load  <= 1'b0;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign loadAcc   = r_load;
  assign rf_we     = r_we;
  assign SelAcc    = r_sel;
  assign alu_op    = r_alu;
  assign imm       = w_opr;
  assign rf_addr   = w_opr;
  assign busy      = r_busy;
  assign halted    = r_halt;

endmodule

// File: doc/acc_ctrl.md
ACC_CTRL -- requirements
Module: acc_ctrl

Interface
REQ-001 SHALL have one parameter: PC_RST, default 8'h00, program counter value loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port CLB  input  1  asynchronous active-low reset (clear).
REQ-004 SHALL have port start  input  1  begins execution from IDLE.
REQ-005 SHALL have port imem_rdata  input  8  instruction byte, opcode [7:4], operand [3:0].
REQ-006 SHALL have port imem_valid  input  1  imem_rdata valid for the current request.
REQ-007 SHALL have port acc_zero  input  1  accumulator equals 8'h00.
REQ-008 SHALL have port imem_req  output  1  instruction fetch request.
REQ-009 SHALL have port imem_addr  output  8  fetch address, equal to pc.
REQ-010 SHALL have port loadAcc  output  1  accumulator load strobe.
REQ-011 SHALL have port SelAcc  output  2  accumulator source: 00 ALU, 01 register file, 10 immediate.
REQ-012 SHALL have port imm  output  4  immediate operand, equal to IR[3:0].
REQ-013 SHALL have port alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
REQ-014 SHALL have port rf_addr  output  4  register file index, equal to IR[3:0].
REQ-015 SHALL have port rf_we  output  1  register file write strobe (writes accumulator).
REQ-016 SHALL have ports busy  output  1  (state not IDLE/HALT) and halted  output  1  (state HALT).

Function
REQ-017 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-018 IDLE SHALL go to FETCH on the cycle after start=1 is sampled; start SHALL be ignored in other states.
REQ-019 FETCH SHALL drive imem_req=1 and imem_addr=pc; on sampling imem_valid=1 it SHALL load IR<=imem_rdata, set pc<=pc+1 (8'hFF wraps to 8'h00) and go to DECODE; otherwise it SHALL hold.
REQ-020 imem_valid outside FETCH SHALL be ignored.
REQ-021 DECODE SHALL last exactly one cycle and then go to EXEC; alu_op and SelAcc SHALL be driven from IR in both DECODE and EXEC.
REQ-022 EXEC SHALL last exactly one cycle; loadAcc and rf_we SHALL pulse only in EXEC, for one cycle each, and never together.
REQ-023 Opcodes: 0000 NOP; 0001 LDI (SelAcc=10, loadAcc); 0010 LDR (SelAcc=01, loadAcc); 0011 STR (rf_we); 0100-1000 ADD/SUB/AND/OR/XOR (SelAcc=00, alu_op 000-100, loadAcc); 1001 JMP (pc<={4'h0,operand}); 1111 HLT.
REQ-024 EXEC SHALL go to FETCH, except HLT, which SHALL go to HALT.
REQ-025 HALT SHALL be left only by reset, with halted=1 and all strobes 0.
REQ-026 Unassigned opcodes SHALL execute as NOP.
REQ-027 Throughput SHALL be 3 cycles per instruction when imem_valid is high in the first FETCH cycle.

Reset
REQ-028 CLB=0 SHALL immediately (asynchronously) force state=IDLE, pc=PC_RST and IR=8'h00, including mid-instruction.
REQ-029 During reset, all outputs SHALL be 0 except imem_addr, which SHALL equal PC_RST.

Configuration
REQ-030 Macro ACC_CTRL_BRANCH_EN defined: 1010 JZ and 1011 JNZ SHALL sample acc_zero in EXEC; when the condition holds, pc<={4'h0,operand}, otherwise pc is unchanged.
REQ-031 Macro ACC_CTRL_BRANCH_EN undefined: 1010 and 1011 SHALL execute as NOP, and acc_zero SHALL be unused.

Verification
REQ-032 Reset, start pulse, program {8'h15, 8'h33, 8'hF0} with imem_valid always 1 -> EXEC cycles show loadAcc,SelAcc=10,imm=5; then rf_we,rf_addr=3; then halted=1 after cycle 9.
REQ-033 imem_valid held low for 4 FETCH cycles -> imem_req stays 1, imem_addr is stable, and pc does not advance until valid.
REQ-034 pc=8'hFF fetching 8'h00 -> pc wraps to 8'h00; JMP 8'h97 -> next imem_addr=8'h07.
REQ-035 With ACC_CTRL_BRANCH_EN and acc_zero=1: JZ 8'hA4 -> imem_addr=8'h04, and JNZ 8'hB4 falls through to pc+1; without the macro, both fall through.
REQ-036 CLB asserted during EXEC of ADD -> loadAcc drops to 0 immediately, state=IDLE, and busy=0 until the next start.
